// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter and its response tracker.
package dmem_arb_pkg;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DBG = 1'b1;

   localparam logic [3:0] WE_READ = 4'b0000;

   localparam int unsigned DMEM_RD_LAT = 2;

   typedef struct packed {
      logic valid;
      logic owner;
   } resp_t;

   function automatic logic is_read(input logic [3:0] we);
      return we == WE_READ;
   endfunction

endpackage

// File: rtl/dmem_resp_tracker.sv
// Fixed-latency shift register tracking {valid, owner} of BRAM reads in flight.
module dmem_resp_tracker
   import dmem_arb_pkg::*;
#(
   parameter int unsigned RD_LAT = DMEM_RD_LAT
) (
   input  logic  clk_i,
   input  logic  rst_i,
   input  resp_t issue_i,
   output resp_t resp_o
);

   resp_t pipe_q [RD_LAT];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(RD_LAT); i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= issue_i;
         for (int i = 1; i < int'(RD_LAT); i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign resp_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data BRAM port between the CPU MEM stage (priority) and the debug/loader master,
// with bounded DBG starvation and per-owner routing of fixed-latency read data.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 13,
   parameter int unsigned RD_LAT     = DMEM_RD_LAT,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,

   input  logic              cpu_req_i,
   input  logic [3:0]        cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [31:0]       cpu_wdata_i,
   output logic              cpu_gnt_o,
   output logic              cpu_stall_o,
   output logic              cpu_rvalid_o,
   output logic [31:0]       cpu_rdata_o,

   input  logic              dbg_req_i,
   input  logic [3:0]        dbg_we_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   input  logic [31:0]       dbg_wdata_i,
   output logic              dbg_gnt_o,
   output logic              dbg_rvalid_o,
   output logic [31:0]       dbg_rdata_o,

   output logic              mem_en_o,
   output logic [3:0]        mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_din_o,
   input  logic [31:0]       mem_dout_i
);

   logic [7:0] starve_q, starve_d;
   logic       dbg_win;
   resp_t      issue, resp;

   assign dbg_win     = (starve_q == 8'(STARVE_MAX));
   assign cpu_gnt_o   = cpu_req_i & ~(dbg_win & dbg_req_i);
   assign dbg_gnt_o   = dbg_req_i & ~cpu_gnt_o;
   assign cpu_stall_o = cpu_req_i & ~cpu_gnt_o;
   assign mem_en_o    = cpu_gnt_o | dbg_gnt_o;

   always_comb begin
      mem_we_o   = '0;
      mem_addr_o = '0;
      mem_din_o  = '0;
      if (cpu_gnt_o) begin
         mem_we_o   = cpu_we_i;
         mem_addr_o = cpu_addr_i;
         mem_din_o  = cpu_wdata_i;
      end else if (dbg_gnt_o) begin
         mem_we_o   = dbg_we_i;
         mem_addr_o = dbg_addr_i;
         mem_din_o  = dbg_wdata_i;
      end
   end

   // A DBG that drops its request forfeits accumulated credit.
   always_comb begin
      starve_d = starve_q;
      if (!dbg_req_i || dbg_gnt_o) begin
         starve_d = '0;
      end else if (!dbg_win) begin
         starve_d = starve_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

   assign issue.valid = mem_en_o & is_read(mem_we_o);
   assign issue.owner = dbg_gnt_o ? OWN_DBG : OWN_CPU;

   dmem_resp_tracker #(
      .RD_LAT (RD_LAT)
   ) u_resp_tracker (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .issue_i (issue),
      .resp_o  (resp)
   );

   assign cpu_rvalid_o = resp.valid & (resp.owner == OWN_CPU);
   assign dbg_rvalid_o = resp.valid & (resp.owner == OWN_DBG);
   assign cpu_rdata_o  = cpu_rvalid_o ? mem_dout_i : 32'h0;
   assign dbg_rdata_o  = dbg_rvalid_o ? mem_dout_i : 32'h0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a two-cycle-latency byte-writable BRAM model.
module tb_dmem_port_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cpu_req_i, dbg_req_i;
   logic [3:0]  cpu_we_i, dbg_we_i;
   logic [12:0] cpu_addr_i, dbg_addr_i;
   logic [31:0] cpu_wdata_i, dbg_wdata_i;
   logic        cpu_gnt_o, cpu_stall_o, cpu_rvalid_o, dbg_gnt_o, dbg_rvalid_o;
   logic [31:0] cpu_rdata_o, dbg_rdata_o;
   logic        mem_en_o;
   logic [3:0]  mem_we_o;
   logic [12:0] mem_addr_o;
   logic [31:0] mem_din_o, mem_dout_i;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   dmem_port_arbiter dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .cpu_req_i    (cpu_req_i),
      .cpu_we_i     (cpu_we_i),
      .cpu_addr_i   (cpu_addr_i),
      .cpu_wdata_i  (cpu_wdata_i),
      .cpu_gnt_o    (cpu_gnt_o),
      .cpu_stall_o  (cpu_stall_o),
      .cpu_rvalid_o (cpu_rvalid_o),
      .cpu_rdata_o  (cpu_rdata_o),
      .dbg_req_i    (dbg_req_i),
      .dbg_we_i     (dbg_we_i),
      .dbg_addr_i   (dbg_addr_i),
      .dbg_wdata_i  (dbg_wdata_i),
      .dbg_gnt_o    (dbg_gnt_o),
      .dbg_rvalid_o (dbg_rvalid_o),
      .dbg_rdata_o  (dbg_rdata_o),
      .mem_en_o     (mem_en_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_din_o    (mem_din_o),
      .mem_dout_i   (mem_dout_i)
   );

   // BRAM: read registered, then output register -> data two cycles after the enabling cycle.
   logic [31:0] bram [8192];
   logic [31:0] rd_stage;

   always @(posedge clk_i) begin
      if (mem_en_o) begin
         if (mem_we_o == 4'b0000) rd_stage <= bram[mem_addr_o];
         for (int b = 0; b < 4; b++) begin
            if (mem_we_o[b]) bram[mem_addr_o][8*b +: 8] <= mem_din_o[8*b +: 8];
         end
      end
      mem_dout_i <= rd_stage;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drv_cpu(input logic req, input logic [3:0] we, input logic [12:0] a,
                          input logic [31:0] d);
      cpu_req_i = req; cpu_we_i = we; cpu_addr_i = a; cpu_wdata_i = d;
   endtask

   task automatic drv_dbg(input logic req, input logic [3:0] we, input logic [12:0] a,
                          input logic [31:0] d);
      dbg_req_i = req; dbg_we_i = we; dbg_addr_i = a; dbg_wdata_i = d;
   endtask

   task automatic chk_no_resp(input string tag);
      chk({tag, "_cpu_rvalid"}, 32'(cpu_rvalid_o), 32'd0);
      chk({tag, "_dbg_rvalid"}, 32'(dbg_rvalid_o), 32'd0);
      chk({tag, "_cpu_rdata"}, cpu_rdata_o, 32'd0);
      chk({tag, "_dbg_rdata"}, dbg_rdata_o, 32'd0);
   endtask

   initial begin
      rst_i = 1'b1;
      drv_cpu(1'b0, 4'h0, 13'h0, 32'h0);
      drv_dbg(1'b0, 4'h0, 13'h0, 32'h0);
      #12;
      chk_no_resp("reset");
      chk("reset_mem_en", 32'(mem_en_o), 32'd0);
      tick();
      rst_i = 1'b0;

      // Idle with non-zero address/data on both ports: BRAM outputs must stay gated to 0.
      drv_cpu(1'b0, 4'hF, 13'h0AA, 32'hCAFEF00D);
      drv_dbg(1'b0, 4'hF, 13'h055, 32'h12345678);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("idle_mem_en", 32'(mem_en_o), 32'd0);
         chk("idle_mem_bus", {mem_we_o, 15'(mem_addr_o), 13'd0} | mem_din_o, 32'd0);
         chk("idle_gnt", {30'd0, cpu_gnt_o, dbg_gnt_o}, 32'd0);
         chk_no_resp("idle");
      end

      // Preload through the CPU port with full-word writes.
      tick(); drv_cpu(1'b1, 4'hF, 13'h010, 32'hDEADBEEF);
      #1; chk("pre_we", 32'(mem_we_o), 32'hF);
      chk("pre_din", mem_din_o, 32'hDEADBEEF);
      tick(); drv_cpu(1'b1, 4'hF, 13'h001, 32'h11);
      tick(); drv_cpu(1'b1, 4'hF, 13'h002, 32'h22);
      tick(); drv_cpu(1'b1, 4'hF, 13'h003, 32'h33);
      tick(); drv_cpu(1'b1, 4'hF, 13'h1FFF, 32'h12345678);
      #1; chk_no_resp("pre_write");
      tick(); drv_cpu(1'b0, 4'h0, 13'h0, 32'h0);
      tick(); tick();

      // Single CPU read: grant same cycle, data two cycles later.
      tick(); drv_cpu(1'b1, 4'h0, 13'h010, 32'h0);
      #1;
      chk("rd_cpu_gnt", 32'(cpu_gnt_o), 32'd1);
      chk("rd_cpu_stall", 32'(cpu_stall_o), 32'd0);
      chk("rd_mem_en", 32'(mem_en_o), 32'd1);
      chk("rd_mem_addr", 32'(mem_addr_o), 32'h010);
      chk("rd_mem_we", 32'(mem_we_o), 32'd0);
      tick(); drv_cpu(1'b0, 4'h0, 13'h0, 32'h0);
      #1; chk_no_resp("rd_lat1");
      tick();
      chk("rd_cpu_rvalid", 32'(cpu_rvalid_o), 32'd1);
      chk("rd_cpu_rdata", cpu_rdata_o, 32'hDEADBEEF);
      chk("rd_dbg_rvalid", 32'(dbg_rvalid_o), 32'd0);
      tick(); chk_no_resp("rd_after");

      // Contention: CPU wins 8 cycles, DBG the 9th, period 9; responses follow 2 cycles later.
      for (int k = 0; k < 18; k++) begin
         tick();
         drv_cpu(1'b1, 4'h0, 13'h010, 32'h0);
         drv_dbg(1'b1, 4'h0, 13'h002, 32'h0);
         #1;
         chk("starve_cpu_gnt", 32'(cpu_gnt_o), 32'((k % 9) != 8));
         chk("starve_dbg_gnt", 32'(dbg_gnt_o), 32'((k % 9) == 8));
         chk("starve_cpu_stall", 32'(cpu_stall_o), 32'((k % 9) == 8));
         if (k >= 2) begin
            chk("starve_cpu_rvalid", 32'(cpu_rvalid_o), 32'(((k - 2) % 9) != 8));
            chk("starve_dbg_rvalid", 32'(dbg_rvalid_o), 32'(((k - 2) % 9) == 8));
            chk("starve_rdata", cpu_rdata_o | dbg_rdata_o,
                (((k - 2) % 9) == 8) ? 32'h22 : 32'hDEADBEEF);
         end
      end
      tick();
      drv_cpu(1'b0, 4'h0, 13'h0, 32'h0);
      drv_dbg(1'b0, 4'h0, 13'h0, 32'h0);
      tick(); tick(); tick();

      // Interleaved reads CPU/DBG/CPU, returned in order per owner.
      tick(); drv_cpu(1'b1, 4'h0, 13'h001, 32'h0);
      #1; chk("il_c0_gnt", 32'(cpu_gnt_o), 32'd1);
      tick(); drv_cpu(1'b0, 4'h0, 13'h0, 32'h0); drv_dbg(1'b1, 4'h0, 13'h002, 32'h0);
      #1; chk("il_d1_gnt", 32'(dbg_gnt_o), 32'd1);
      chk("il_d1_addr", 32'(mem_addr_o), 32'h002);
      tick(); drv_dbg(1'b0, 4'h0, 13'h0, 32'h0); drv_cpu(1'b1, 4'h0, 13'h003, 32'h0);
      #1; chk("il_c2_gnt", 32'(cpu_gnt_o), 32'd1);
      chk("il_r0_cpu_rvalid", 32'(cpu_rvalid_o), 32'd1);
      chk("il_r0_cpu_rdata", cpu_rdata_o, 32'h11);
      chk("il_r0_dbg_rvalid", 32'(dbg_rvalid_o), 32'd0);
      tick(); drv_cpu(1'b0, 4'h0, 13'h0, 32'h0);
      #1;
      chk("il_r1_dbg_rvalid", 32'(dbg_rvalid_o), 32'd1);
      chk("il_r1_dbg_rdata", dbg_rdata_o, 32'h22);
      chk("il_r1_cpu_rvalid", 32'(cpu_rvalid_o), 32'd0);
      chk("il_r1_cpu_rdata", cpu_rdata_o, 32'd0);
      tick();
      chk("il_r2_cpu_rvalid", 32'(cpu_rvalid_o), 32'd1);
      chk("il_r2_cpu_rdata", cpu_rdata_o, 32'h33);
      chk("il_r2_dbg_rvalid", 32'(dbg_rvalid_o), 32'd0);
      tick(); chk_no_resp("il_done");

      // DBG byte write to the top address, then read it back.
      tick(); drv_dbg(1'b1, 4'b0100, 13'h1FFF, 32'h00AB0000);
      #1;
      chk("bw_gnt", 32'(dbg_gnt_o), 32'd1);
      chk("bw_mem_en", 32'(mem_en_o), 32'd1);
      chk("bw_mem_we", 32'(mem_we_o), 32'h4);
      chk("bw_mem_addr", 32'(mem_addr_o), 32'h1FFF);
      chk("bw_mem_din", mem_din_o, 32'h00AB0000);
      tick(); drv_dbg(1'b0, 4'h0, 13'h0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         #1; chk_no_resp("bw_no_resp");
         tick();
      end
      drv_dbg(1'b1, 4'h0, 13'h1FFF, 32'h0);
      #1; chk("bw_rd_gnt", 32'(dbg_gnt_o), 32'd1);
      tick(); drv_dbg(1'b0, 4'h0, 13'h0, 32'h0);
      tick();
      chk("bw_rd_rvalid", 32'(dbg_rvalid_o), 32'd1);
      chk("bw_rd_rdata", dbg_rdata_o, 32'h12AB5678);

      // Build DBG credit, issue a CPU read, then reset while it is in flight.
      for (int k = 0; k < 5; k++) begin
         tick();
         drv_cpu(1'b1, 4'hF, 13'h100, 32'h0);
         drv_dbg(1'b1, 4'h0, 13'h002, 32'h0);
      end
      tick(); drv_cpu(1'b1, 4'h0, 13'h010, 32'h0);
      #1; chk("rst_pre_gnt", 32'(cpu_gnt_o), 32'd1);
      tick(); drv_cpu(1'b1, 4'hF, 13'h100, 32'h0);
      rst_i = 1'b1;
      #1; chk_no_resp("rst_a1");
      tick(); chk_no_resp("rst_a2");
      tick(); rst_i = 1'b0;
      for (int k = 0; k < 9; k++) begin
         if (k > 0) tick();
         #1;
         chk("rst_cpu_gnt", 32'(cpu_gnt_o), 32'(k < 8));
         chk("rst_dbg_gnt", 32'(dbg_gnt_o), 32'(k == 8));
         chk("rst_cpu_stall", 32'(cpu_stall_o), 32'(k == 8));
         chk_no_resp("rst_post");
      end
      tick();
      drv_cpu(1'b0, 4'h0, 13'h0, 32'h0);
      drv_dbg(1'b0, 4'h0, 13'h0, 32'h0);
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-BRAM port (13-bit word address, 4-bit byte write-enable, 32-bit data) between two requesters.
  - The pipeline MEM stage (CPU) has priority.
  - The debug/loader master (DBG) backs up the test environment and program loading.
- Grants one requester per cycle and drives the BRAM control signals.
- Tracks outstanding reads through the fixed BRAM read latency and returns read data to the requester that issued it.
- Bounds DBG starvation by periodically forcing a CPU stall.

Parameters:
- ADDR_W, 13, word address width into BRAM.
- RD_LAT, 2, cycles from grant to read data valid on mem_dout_i (BRAM read plus output capture); legal 1..4.
- STARVE_MAX, 8, consecutive DBG denials before DBG wins arbitration; legal 1..255.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- cpu_req_i  in  1  CPU access request
- cpu_we_i  in  4  CPU byte write mask; 0000 = read
- cpu_addr_i  in  ADDR_W  CPU word address
- cpu_wdata_i  in  32  CPU store data
- cpu_gnt_o  out  1  CPU request accepted this cycle
- cpu_stall_o  out  1  CPU request pending but not granted
- cpu_rvalid_o  out  1  CPU read data valid
- cpu_rdata_o  out  32  CPU read data
- dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i  in  1/4/ADDR_W/32  DBG request, same encoding as CPU
- dbg_gnt_o, dbg_rvalid_o  out  1  DBG grant and read valid
- dbg_rdata_o  out  32  DBG read data
- mem_en_o  out  1  BRAM enable
- mem_we_o  out  4  BRAM byte write enable
- mem_addr_o  out  ADDR_W  BRAM address
- mem_din_o  out  32  BRAM write data
- mem_dout_i  in  32  BRAM read data, valid RD_LAT cycles after the enabling cycle

Behaviour:
- Grant logic is combinational from the requests and the starvation counter.
- Priority:
  - dbg_win = (starve_cnt == STARVE_MAX).
  - cpu_gnt_o = cpu_req_i & ~(dbg_win & dbg_req_i).
  - dbg_gnt_o = dbg_req_i & ~cpu_gnt_o.
  - Grants are never both high.
- cpu_stall_o = cpu_req_i & ~cpu_gnt_o.
- BRAM drive:
  - mem_en_o = cpu_gnt_o | dbg_gnt_o.
  - mem_we_o/mem_addr_o/mem_din_o come from the granted requester.
  - When mem_en_o is low these outputs are 0.
- Writes complete at grant; they produce no rvalid.
- Starvation counter (8 bit, registered):
  - dbg_req_i & ~dbg_gnt_o: increment, saturating at STARVE_MAX.
  - dbg_gnt_o: clear to 0.
  - ~dbg_req_i: clear to 0 (DBG deasserting its request forfeits its credit).
- Response tracker: RD_LAT-deep shift register of {valid, owner}.
  - Stage 0 loads valid = mem_en_o & (mem_we_o == 0) and owner = dbg_gnt_o.
  - The last stage drives the outputs:
    - cpu_rvalid_o = v & ~owner; dbg_rvalid_o = v & owner.
    - x_rdata_o = mem_dout_i when the matching rvalid is high, else 0.
- Reads issued on back-to-back cycles produce back-to-back responses in issue order; a mixed CPU/DBG sequence is returned per owner without reordering.
- Reset (async, any cycle):
  - Tracker cleared and starve_cnt = 0.
  - cpu_rvalid_o = dbg_rvalid_o = 0; rdata outputs = 0.
  - Reads in flight are dropped, with no response after reset release.
  - Combinational grant outputs follow the requests immediately after reset release.
- Simultaneous request with dbg_win: DBG is granted, the CPU stalls exactly one cycle, and the counter clears.
- Requests are not held or latched. A denied requester must hold req/addr/data stable until granted.

Decomposition:
- Shared package dmem_arb_pkg:
  - owner encoding OWN_CPU = 0, OWN_DBG = 1.
  - Write-enable constant WE_READ = 4'b0000.
  - Default latency constant DMEM_RD_LAT = 2.
- Sub-module dmem_resp_tracker (parameter RD_LAT): the valid/owner shift register with async reset. It is also reused by the instruction-side loader port.

Test Plan:
- Idle: no requests for 10 cycles -> mem_en_o = 0, all grants/rvalids 0, starve_cnt stays 0.
- CPU read at addr 0x010 with BRAM word 0xDEADBEEF -> cpu_gnt_o same cycle; cpu_rvalid_o and cpu_rdata_o = 0xDEADBEEF exactly 2 cycles later; dbg_rvalid_o stays 0.
- CPU and DBG both requesting continuously, STARVE_MAX = 8 -> CPU granted 8 cycles, DBG granted on the 9th with cpu_stall_o = 1 that cycle; the pattern repeats with period 9.
- Interleaved reads CPU@0x001, DBG@0x002, CPU@0x003 on consecutive cycles (data 0x11/0x22/0x33) -> rvalids at cycles +2,+3,+4 routed CPU/DBG/CPU with the matching data.
- DBG byte write we = 0100 at 0x1FFF with data 0x00AB0000 while the CPU is idle -> mem_we_o = 0100, mem_addr_o = 0x1FFF; no rvalid follows.
- Assert rst_i one cycle after a CPU read grant -> no cpu_rvalid_o ever appears for that read; starve_cnt = 0; grants resume on the first cycle after release.
